restoring_divider: RTL and testbench

- Sequential inverse of the array multiplier: takes a 2N-bit product-width dividend and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder.
- Uses a restoring shift-subtract algorithm that resolves one quotient bit per clock.
- Operand capture and result delivery use a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath, so that p = a*b + r can be undone to recover a and r.

---
 rtl/restoring_divider.sv | 129 ++++++++++++
 tb/tb_restoring_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock,
// with a start/busy/done handshake and an overflow/divide-by-zero flag.
module restoring_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] p,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           ovf,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_sr;
  logic [N-1:0]    r_quo;
  logic [N-1:0]    r_b;
  logic [CW-1:0]   r_cnt;

  logic [N:0]      w_t;
  logic [N:0]      w_diff;
  logic            w_ge;
  logic            w_ovf;
  logic [N-1:0]    w_rem_nxt;
  logic [N-1:0]    w_quo_nxt;

  // Partial remainder widened by the next dividend bit; rem < b keeps it below 2b.
  assign w_t    = {r_rem, r_sr[N-1]};
  assign w_diff = w_t - {1'b0, r_b};
  assign w_ge   = (w_t >= {1'b0, r_b});
  assign w_ovf  = (p[2*N-1:N] >= b);

  // One restoring step: subtract when it fits, otherwise keep the shifted remainder.
  always_comb begin
    w_rem_nxt = w_t[N-1:0];
    w_quo_nxt = {r_quo[N-2:0], 1'b0};
    if (w_ge) begin
      w_rem_nxt = w_diff[N-1:0];
      w_quo_nxt = {r_quo[N-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_t[N-1:0];
      w_quo_nxt = {r_quo[N-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_sr    <= '0;
      r_quo   <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      q       <= '0;
      r       <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            r_b <= b;
            if (w_ovf) begin
              q       <= '1;
              r       <= '0;
              ovf     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= p[2*N-1:N];
              r_sr    <= p[N-1:0];
              r_quo   <= '0;
              r_cnt   <= CW'(N);
              busy    <= 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_sr  <= {r_sr[N-2:0], 1'b0};
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Results are published only at completion so q/r/ovf hold between operations.
          if (r_cnt == CW'(1)) begin
            q       <= w_quo_nxt;
            r       <= w_rem_nxt;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed scenarios, exhaustive back-to-back sweep,
// and random operations against an arithmetic reference model.
module tb_restoring_divider;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] p;
  logic [N-1:0]   b;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           ovf;
  logic           busy;
  logic           done;

  int n_vec = 0;
  int n_err = 0;

  int             dc, dn, bc, he;
  logic [N-1:0]   dq, dr;
  logic           dovf;

  restoring_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .b     (b),
    .q     (q),
    .r     (r),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, overflow when the quotient cannot fit in N bits.
  function automatic void model(input int pv, input int bv, output int eq, output int er, output int eo);
    if ((pv >> N) >= bv) begin
      eq = (1 << N) - 1; er = 0; eo = 1;
    end else begin
      eq = pv / bv; er = pv % bv; eo = 0;
    end
  endfunction

  // Launch one operation from IDLE, optionally inject a second start at negedge inj_c.
  task automatic do_op(input logic [2*N-1:0] pv, input logic [N-1:0] bv, input int inj_c,
                       input logic [2*N-1:0] ip, input logic [N-1:0] ib);
    logic [N-1:0] prev_q, prev_r;
    prev_q = q; prev_r = r;
    dc = 0; dn = 0; bc = 0; he = 0; dq = '0; dr = '0; dovf = 1'b0;
    @(negedge clk);
    start = 1'b1; p = pv; b = bv;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        dn++;
        if (dc == 0) begin dc = c; dq = q; dr = r; dovf = ovf; end
      end
      if (dc == 0 && (q !== prev_q || r !== prev_r)) he++;
      if (c == inj_c) begin
        start = 1'b1; p = ip; b = ib;
      end else begin
        start = 1'b0; p = 8'($urandom); b = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; p = '0; b = '0;
    #12;
    n_vec++;
    if ({q, r, ovf, busy, done} !== 11'd0) begin
      n_err++; $display("FAIL reset_during: got %b want 0", {q, r, ovf, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({q, r, ovf, busy, done} !== 11'd0) begin
      n_err++; $display("FAIL reset_after: got %b want 0", {q, r, ovf, busy, done});
    end
  endtask

  task automatic test_basic;
    do_op(8'd23, 4'd5, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'd4, 4'd3, 1'b0}) begin
      n_err++; $display("FAIL basic_23_5: got q=%0d r=%0d ovf=%0d want 4 3 0", dq, dr, dovf);
    end
    n_vec++;
    if (dc !== 5 || bc !== 4 || dn !== 1) begin
      n_err++; $display("FAIL basic_timing: got done@%0d busy=%0d pulses=%0d want 5 4 1", dc, bc, dn);
    end
    do_op(8'd225, 4'd15, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'd15, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL basic_225_15: got q=%0d r=%0d ovf=%0d want 15 0 0", dq, dr, dovf);
    end
    n_vec++;
    if (he !== 0) begin
      n_err++; $display("FAIL result_hold: got %0d early changes want 0", he);
    end
    do_op(8'd14, 4'd15, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'd0, 4'd14, 1'b0}) begin
      n_err++; $display("FAIL basic_14_15: got q=%0d r=%0d ovf=%0d want 0 14 0", dq, dr, dovf);
    end
  endtask

  task automatic test_overflow;
    do_op(8'd7, 4'd0, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'hF, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL ovf_div0: got q=%0d r=%0d ovf=%0d want 15 0 1", dq, dr, dovf);
    end
    n_vec++;
    if (dc !== 1 || bc !== 0 || dn !== 1) begin
      n_err++; $display("FAIL ovf_timing: got done@%0d busy=%0d pulses=%0d want 1 0 1", dc, bc, dn);
    end
    do_op(8'd80, 4'd5, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'hF, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL ovf_80_5: got q=%0d r=%0d ovf=%0d want 15 0 1", dq, dr, dovf);
    end
    n_vec++;
    if (q !== 4'hF || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_hold: got q=%0d ovf=%0d want 15 1", q, ovf);
    end
  endtask

  task automatic test_ignore_busy;
    do_op(8'd23, 4'd5, 2, 8'd100, 4'd9);
    n_vec++;
    if ({dq, dr, dovf} !== {4'd4, 4'd3, 1'b0} || dn !== 1) begin
      n_err++; $display("FAIL ignore_busy: got q=%0d r=%0d ovf=%0d pulses=%0d want 4 3 0 1", dq, dr, dovf, dn);
    end
    do_op(8'd100, 4'd9, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'd11, 4'd1, 1'b0}) begin
      n_err++; $display("FAIL after_ignore: got q=%0d r=%0d ovf=%0d want 11 1 0", dq, dr, dovf);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    start = 1'b1; p = 8'd23; b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy: got busy=%0d want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({q, r, ovf, busy, done} !== 11'd0) begin
      n_err++; $display("FAIL async_reset: got %b want 0", {q, r, ovf, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    do_op(8'd23, 4'd5, 0, 8'd0, 4'd0);
    n_vec++;
    if ({dq, dr, dovf} !== {4'd4, 4'd3, 1'b0} || dc !== 5) begin
      n_err++; $display("FAIL post_reset: got q=%0d r=%0d ovf=%0d done@%0d want 4 3 0 5", dq, dr, dovf, dc);
    end
  endtask

  // Every legal (a, b, r) with start held high: one result every N+2 cycles.
  task automatic test_back_to_back;
    int cyc, last, waited;
    bit first;
    cyc = 0; last = 0; first = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int bb = 1; bb < 16; bb++) begin
      for (int aa = 0; aa < 16; aa++) begin
        for (int rr = 0; rr < bb; rr++) begin
          p = 8'(aa * bb + rr); b = 4'(bb);
          waited = 0;
          do begin
            @(negedge clk); cyc++; waited++;
          end while (done !== 1'b1 && waited < 20);
          n_vec++;
          if (done !== 1'b1) begin
            n_err++; $display("FAIL b2b_timeout: a=%0d b=%0d r=%0d no done in %0d cycles", aa, bb, rr, waited);
          end else if ({q, r, ovf} !== {4'(aa), 4'(rr), 1'b0}) begin
            n_err++; $display("FAIL b2b_result: p=%0d b=%0d got q=%0d r=%0d ovf=%0d want %0d %0d 0",
                              aa * bb + rr, bb, q, r, ovf, aa, rr);
          end
          if (!first) begin
            n_vec++;
            if (cyc - last !== N + 2) begin
              n_err++; $display("FAIL b2b_period: got %0d cycles want %0d", cyc - last, N + 2);
            end
          end
          last = cyc; first = 1'b0;
        end
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random;
    int eq, er, eo;
    logic [2*N-1:0] pv;
    logic [N-1:0] bv;
    for (int i = 0; i < 60; i++) begin
      bv = 4'($urandom_range(0, 15));
      pv = 8'($urandom_range(0, 255));
      if (bv != 4'd0 && $urandom_range(0, 1) == 1) pv[7:4] = 4'($urandom_range(0, int'(bv) - 1));
      model(int'(pv), int'(bv), eq, er, eo);
      do_op(pv, bv, 0, 8'd0, 4'd0);
      n_vec++;
      if ({dq, dr, dovf} !== {4'(eq), 4'(er), 1'(eo)} || dn !== 1 || dc !== (eo ? 1 : N + 1)) begin
        n_err++; $display("FAIL random: p=%0d b=%0d got q=%0d r=%0d ovf=%0d done@%0d want %0d %0d %0d %0d",
                          pv, bv, dq, dr, dovf, dc, eq, er, eo, eo ? 1 : N + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
